// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared encodings and stage packet for the RV32M multiply pipe
package mult_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef struct packed {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic [31:0]     instr;
        logic [31:0]     pc;
    } stage_pkt_t;

    // funct3[2]=1 selects the divide group, which this pipe does not execute
    function automatic logic is_mul_instr(input logic [31:0] instr);
        return (instr[31:25] == FUNCT7_MULDIV) && (instr[6:0] == OPCODE_OP) && !instr[14];
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - one packet register of the multiply pipe with stall, kill and reset
module mult_pipe_stage
    import mult_pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kill_i,
    input  logic       stall_i,
    input  stage_pkt_t pkt_i,
    output stage_pkt_t pkt_o
);

    stage_pkt_t pkt_q;
    stage_pkt_t pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        if (kill_i) begin
            pkt_d = '0;
        end else if (!stall_i) begin
            pkt_d = pkt_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign pkt_o = pkt_q;

endmodule

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined RV32M MUL/MULH/MULHSU/MULHU unit with decode hazard query
// Optional feature: MULT_PERF_CNT_EN adds retired-multiply and stall-cycle counters.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            kill_i,
    input  logic            stall_i,
    input  logic [31:0]     mult1_instruction_i,
    input  logic [31:0]     mult1_pc_i,
    input  logic [4:0]      mult1_write_addr_i,
    input  logic            mult1_int_write_enable_i,
    input  logic [XLEN-1:0] mult1_src1_i,
    input  logic [XLEN-1:0] mult1_src2_i,
    input  logic [4:0]      hz_rs1_i,
    input  logic [4:0]      hz_rs2_i,
    output logic            hz_stall_o,
`ifdef MULT_PERF_CNT_EN
    output logic [31:0]     perf_mul_cnt_o,
    output logic [31:0]     perf_stall_cnt_o,
`endif
    output logic [XLEN-1:0] wb_int_write_data_o,
    output logic [4:0]      wb_write_addr_o,
    output logic            wb_int_write_enable_o,
    output logic [31:0]     wb_instruction_o,
    output logic [31:0]     wb_pc_o
);

    logic                   accept_mul;
    logic [2:0]             funct3;
    logic                   src1_signed;
    logic                   src2_signed;
    logic signed [XLEN:0]   op_a;
    logic signed [XLEN:0]   op_b;
    logic signed [2*XLEN-1:0] product;
    stage_pkt_t             entry_pkt;
    stage_pkt_t             stage_in  [NUM_STAGES];
    stage_pkt_t             stage_out [NUM_STAGES];

    // 33-bit extension lets one signed multiplier cover all four signedness cases
    always_comb begin
        funct3      = mult1_instruction_i[14:12];
        accept_mul  = is_mul_instr(mult1_instruction_i) && mult1_int_write_enable_i;
        src1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        src2_signed = (funct3 == F3_MULH);
        op_a        = {src1_signed & mult1_src1_i[XLEN-1], mult1_src1_i};
        op_b        = {src2_signed & mult1_src2_i[XLEN-1], mult1_src2_i};
        product     = op_a * op_b;

        entry_pkt       = '0;
        entry_pkt.instr = mult1_instruction_i;
        entry_pkt.pc    = mult1_pc_i;
        entry_pkt.addr  = mult1_write_addr_i;
        if (accept_mul) begin
            entry_pkt.we   = (mult1_write_addr_i != 5'd0);
            entry_pkt.data = (funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign stage_in[g] = entry_pkt;
        end else begin : g_rest
            assign stage_in[g] = stage_out[g-1];
        end

        mult_pipe_stage u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .kill_i  (kill_i),
            .stall_i (stall_i),
            .pkt_i   (stage_in[g]),
            .pkt_o   (stage_out[g])
        );
    end

    // The final stage is visible to decode through the write-back forwarding path
    always_comb begin
        hz_stall_o = 1'b0;
        for (int i = 0; i < NUM_STAGES - 1; i++) begin
            if (stage_out[i].we && (stage_out[i].addr != 5'd0) &&
                ((stage_out[i].addr == hz_rs1_i) || (stage_out[i].addr == hz_rs2_i))) begin
                hz_stall_o = 1'b1;
            end
        end
    end

    assign wb_int_write_data_o   = stage_out[NUM_STAGES-1].data;
    assign wb_write_addr_o       = stage_out[NUM_STAGES-1].addr;
    assign wb_int_write_enable_o = stage_out[NUM_STAGES-1].we;
    assign wb_instruction_o      = stage_out[NUM_STAGES-1].instr;
    assign wb_pc_o               = stage_out[NUM_STAGES-1].pc;

`ifdef MULT_PERF_CNT_EN
    logic [31:0] mul_cnt_q, mul_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        any_valid;

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            any_valid = any_valid | stage_out[i].we;
        end
        mul_cnt_d   = mul_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!kill_i && !stall_i && stage_in[NUM_STAGES-1].we) begin
            mul_cnt_d = mul_cnt_q + 32'd1;
        end
        if (stall_i && any_valid) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_mul_cnt_o   = mul_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
